// File: rtl/uart_alu_sequencer.sv
// Sequencer between the UART rx/tx pair and the ALU: gathers A, B and opcode, sends back one result byte.
// Optional inter-byte timeout enabled by defining UART_SEQ_TIMEOUT_EN.
module uart_alu_sequencer #(
    parameter int DATA_BITS     = 8,
    parameter int OP_BITS       = 6,
    parameter int TIMEOUT_TICKS = 153600,
    parameter int TIMEOUT_W     = 18
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx_done,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic [DATA_BITS-1:0] alu_result,
    input  logic                 tx_done,
    output logic [DATA_BITS-1:0] alu_a,
    output logic [DATA_BITS-1:0] alu_b,
    output logic [OP_BITS-1:0]   alu_op,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_start,
    output logic                 busy,
    output logic                 frame_err
);

    // state      | meaning
    // S_A        | idle, waiting for operand A
    // S_B        | waiting for operand B
    // S_OP       | waiting for opcode
    // S_CALC     | ALU settle cycle, result captured on exit
    // S_TX_START | transmit request is high
    // S_TX_WAIT  | waiting for the transmitter to finish
    localparam logic [2:0] S_A        = 3'd0;
    localparam logic [2:0] S_B        = 3'd1;
    localparam logic [2:0] S_OP       = 3'd2;
    localparam logic [2:0] S_CALC     = 3'd3;
    localparam logic [2:0] S_TX_START = 3'd4;
    localparam logic [2:0] S_TX_WAIT  = 3'd5;

    localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_TICKS);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] alu_a_q, alu_a_d;
    logic [DATA_BITS-1:0] alu_b_q, alu_b_d;
    logic [OP_BITS-1:0]   alu_op_q, alu_op_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 timeout;

`ifdef UART_SEQ_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TO_LIMIT - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 in_window;

    // The tick that would bring the count to TIMEOUT_TICKS fires the timeout.
    always_comb begin
        in_window = (state_q == S_B) || (state_q == S_OP);
        timeout   = in_window && tick && (cnt_q == TO_LAST);
        cnt_d     = cnt_q;
        if (!in_window || timeout || rx_done) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tick;
    assign unused_tick = ^{tick, TO_LIMIT};
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        frame_err_d = timeout;
        case (state_q)
            S_A: begin
                if (rx_done) begin
                    alu_a_d = rx_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (timeout) begin
                    state_d = S_A;
                end else if (rx_done) begin
                    alu_b_d = rx_data;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (timeout) begin
                    state_d = S_A;
                end else if (rx_done) begin
                    alu_op_d = rx_data[OP_BITS-1:0];
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                tx_data_d  = alu_result;
                tx_start_d = 1'b1;
                state_d    = S_TX_START;
            end
            S_TX_START: begin
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_done) begin
                    state_d = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
        // busy is registered, so it follows the next state
        busy_d = (state_d == S_CALC) || (state_d == S_TX_START) || (state_d == S_TX_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
